// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: single-cycle ALU plus iterative signed/unsigned multiply/divide with HI/LO registers.
module alu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [5:0]       alu_op,
    input  logic [5:0]       func,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             wr_file,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             div_by_zero
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] LAST = (SW+1)'(WIDTH-1);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state;
    logic [SW:0] cnt;
    logic [2*WIDTH-1:0] mcand, prod, prod_nx, mul_fin;
    logic [WIDTH-1:0] mplier, divisor, op1, quo_nx, q_fin, r_fin, fin_hi, fin_lo, res_c, mag1, mag2;
    logic [WIDTH:0] rem, shifted, diff, rem_nx;
    logic neg_q, neg_r, dz, wr_c, is_mul, is_div, sgn, a_neg, b_neg;
    logic [SW-1:0] shamt;
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign shamt = input1[SW-1:0];
    assign a_neg = sgn & input1[WIDTH-1];
    assign b_neg = sgn & input2[WIDTH-1];
    assign mag1 = a_neg ? -input1 : input1;
    assign mag2 = b_neg ? -input2 : input2;
    assign prod_nx = prod + (mplier[0] ? mcand : '0);
    assign mul_fin = neg_q ? -prod_nx : prod_nx;
    // Restoring step: mplier doubles as the dividend/quotient shift register during DIV.
    assign shifted = {rem[WIDTH-1:0], mplier[WIDTH-1]};
    assign diff = shifted - {1'b0, divisor};
    assign rem_nx = diff[WIDTH] ? shifted : diff;
    assign quo_nx = {mplier[WIDTH-2:0], ~diff[WIDTH]};
    assign q_fin = neg_q ? -quo_nx : quo_nx;
    assign r_fin = neg_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
    assign fin_lo = state == MUL ? mul_fin[WIDTH-1:0] : (dz ? '1 : q_fin);
    assign fin_hi = state == MUL ? mul_fin[2*WIDTH-1:WIDTH] : (dz ? op1 : r_fin);
    always_comb begin
        res_c = '0;
        wr_c = 1'b0;
        is_mul = 1'b0;
        is_div = 1'b0;
        sgn = 1'b0;
        if (alu_op == 6'b000000) begin
            wr_c = 1'b1;
            case (func)
                6'b100000, 6'b100001: res_c = input1 + input2;
                6'b100010, 6'b100011: res_c = input1 - input2;
                6'b100100: res_c = input1 & input2;
                6'b100101: res_c = input1 | input2;
                6'b100110: res_c = input1 ^ input2;
                6'b100111: res_c = ~(input1 | input2);
                6'b101010: res_c = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)};
                6'b101011: res_c = {{(WIDTH-1){1'b0}}, input1 < input2};
                6'b000100: res_c = input2 << shamt;
                6'b000110: res_c = input2 >> shamt;
                6'b000111: res_c = $signed(input2) >>> shamt;
                6'b010000: res_c = hi;
                6'b010010: res_c = lo;
                6'b011000: begin is_mul = 1'b1; sgn = 1'b1; wr_c = 1'b0; end
                6'b011001: begin is_mul = 1'b1; wr_c = 1'b0; end
                6'b011010: begin is_div = 1'b1; sgn = 1'b1; wr_c = 1'b0; end
                6'b011011: begin is_div = 1'b1; wr_c = 1'b0; end
                default: wr_c = 1'b0;
            endcase
        end else begin
            case (alu_op)
                6'b001000, 6'b100011: begin res_c = input1 + input2; wr_c = 1'b1; end
                6'b101011: res_c = input1 + input2;
                6'b001100: begin res_c = input1 & input2; wr_c = 1'b1; end
                6'b001101: begin res_c = input1 | input2; wr_c = 1'b1; end
                6'b001010: begin res_c = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)}; wr_c = 1'b1; end
                6'b000100, 6'b000101: res_c = input1 - input2;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            mcand <= '0;
            prod <= '0;
            mplier <= '0;
            divisor <= '0;
            rem <= '0;
            op1 <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
            out_valid <= 1'b0;
            result <= '0;
            zero <= 1'b1;
            wr_file <= 1'b0;
            hi <= '0;
            lo <= '0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && (is_mul || is_div)) begin
                    state <= is_mul ? MUL : DIV;
                    cnt <= '0;
                    mcand <= {{WIDTH{1'b0}}, mag1};
                    mplier <= is_mul ? mag2 : mag1;
                    prod <= '0;
                    rem <= '0;
                    divisor <= mag2;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    dz <= input2 == '0;
                    op1 <= input1;
                end else if (in_valid) begin
                    out_valid <= 1'b1;
                    result <= res_c;
                    zero <= res_c == '0;
                    wr_file <= wr_c;
                    div_by_zero <= 1'b0;
                end
            end else begin
                prod <= prod_nx;
                mcand <= mcand << 1;
                mplier <= state == MUL ? mplier >> 1 : quo_nx;
                rem <= rem_nx;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state <= IDLE;
                    out_valid <= 1'b1;
                    hi <= fin_hi;
                    lo <= fin_lo;
                    result <= fin_lo;
                    zero <= fin_lo == '0;
                    wr_file <= 1'b0;
                    div_by_zero <= state == DIV && dz;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: vector table, multi-cycle corner sequences and randomized ops against a reference model.
module tb_alu_muldiv_unit;
    logic clk = 1'b0, rst_n, in_valid, in_ready, out_valid, zero, wr_file, busy, div_by_zero;
    logic [31:0] input1, input2, result, hi, lo;
    logic [5:0] alu_op, func;
    int total = 0, bad = 0;
    logic [31:0] m_hi, m_lo;
    logic m_dz;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .input1(input1), .input2(input2), .alu_op(alu_op), .func(func),
        .out_valid(out_valid), .result(result), .zero(zero), .wr_file(wr_file),
        .hi(hi), .lo(lo), .busy(busy), .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [5:0] op, fn;
        logic [31:0] a, b, res;
        logic z, w;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        alu_op = op; func = fn; input1 = a; input2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    // Architectural reference: plain arithmetic on full-width integers.
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic w, output bit multi);
        longint p;
        r = '0; w = 1'b0; multi = 1'b0; m_dz = 1'b0;
        if (op == 6'h00) begin
            w = 1'b1;
            case (fn)
                6'h20, 6'h21: r = a + b;
                6'h22, 6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2b: r = (a < b) ? 32'd1 : 32'd0;
                6'h04: r = b << a[4:0];
                6'h06: r = b >> a[4:0];
                6'h07: r = $signed(b) >>> a[4:0];
                6'h10: r = m_hi;
                6'h12: r = m_lo;
                6'h18, 6'h19: begin
                    p = (fn == 6'h18) ? longint'($signed(a)) * longint'($signed(b))
                                      : longint'({32'd0, a}) * longint'({32'd0, b});
                    {m_hi, m_lo} = p;
                    multi = 1'b1;
                end
                6'h1a, 6'h1b: begin
                    multi = 1'b1;
                    if (b == 0) begin
                        m_lo = '1; m_hi = a; m_dz = 1'b1;
                    end else if (fn == 6'h1a) begin
                        p = longint'($signed(a)) / longint'($signed(b));
                        m_lo = p[31:0];
                        p = longint'($signed(a)) % longint'($signed(b));
                        m_hi = p[31:0];
                    end else begin
                        m_lo = a / b;
                        m_hi = a % b;
                    end
                end
                default: w = 1'b0;
            endcase
            if (multi) begin
                w = 1'b0;
                r = m_lo;
            end
        end else begin
            case (op)
                6'h08, 6'h23: begin r = a + b; w = 1'b1; end
                6'h2b: r = a + b;
                6'h0c: begin r = a & b; w = 1'b1; end
                6'h0d: begin r = a | b; w = 1'b1; end
                6'h0a: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; w = 1'b1; end
                6'h04, 6'h05: r = a - b;
                default: ;
            endcase
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, pulses;
        logic [31:0] er, ea, eb;
        logic ew;
        bit multi;
        logic [5:0] ops[28] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h08, 6'h23, 6'h2b, 6'h0c, 6'h0d, 6'h0a, 6'h04, 6'h3f};
        logic [5:0] fns[28] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                                6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h3f,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; func = '0; input1 = '0; input2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0); chk("rst_zero", zero, 1); chk("rst_wr", wr_file, 0);
        chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_busy", busy, 0); chk("rst_dbz", div_by_zero, 0);
        @(negedge clk) rst_n = 1'b1;

        tv.push_back('{6'h00, 6'h20, 32'd100, 32'd99, 32'd199, 1'b0, 1'b1});
        tv.push_back('{6'h00, 6'h21, 32'd100, 32'd99, 32'd199, 1'b0, 1'b1});
        tv.push_back('{6'h23, 6'h00, 32'd100, 32'd99, 32'd199, 1'b0, 1'b1});
        tv.push_back('{6'h2b, 6'h00, 32'd100, 32'd99, 32'd199, 1'b0, 1'b0});
        tv.push_back('{6'h00, 6'h22, 32'd99, 32'd99, 32'd0, 1'b1, 1'b1});
        tv.push_back('{6'h04, 6'h00, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0});
        tv.push_back('{6'h05, 6'h00, 32'd5, 32'd4, 32'd1, 1'b0, 1'b0});
        tv.push_back('{6'h00, 6'h2a, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b1});
        tv.push_back('{6'h00, 6'h2b, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b1});
        tv.push_back('{6'h00, 6'h07, 32'd4, 32'h80000000, 32'hF8000000, 1'b0, 1'b1});
        tv.push_back('{6'h00, 6'h06, 32'd4, 32'h80000000, 32'h08000000, 1'b0, 1'b1});
        tv.push_back('{6'h00, 6'h04, 32'd4, 32'd1, 32'd16, 1'b0, 1'b1});
        tv.push_back('{6'h00, 6'h27, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1});
        tv.push_back('{6'h00, 6'h26, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1'b1});
        tv.push_back('{6'h0c, 6'h15, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b1});
        tv.push_back('{6'h0d, 6'h00, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b1});
        tv.push_back('{6'h0a, 6'h00, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'd1, 1'b0, 1'b1});
        tv.push_back('{6'h08, 6'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b1});
        tv.push_back('{6'h00, 6'h23, 32'd1, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b1});
        tv.push_back('{6'h3f, 6'h20, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0});
        tv.push_back('{6'h00, 6'h00, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0});
        foreach (tv[i]) begin
            run(tv[i].op, tv[i].fn, tv[i].a, tv[i].b, lat);
            chk($sformatf("vec%0d_lat", i), lat, 0);
            chk($sformatf("vec%0d_res", i), result, tv[i].res);
            chk($sformatf("vec%0d_zero", i), zero, tv[i].z);
            chk($sformatf("vec%0d_wr", i), wr_file, tv[i].w);
            @(posedge clk);
            #1 chk($sformatf("vec%0d_pulse", i), out_valid, 0);
        end

        // Back-to-back accepts while in_valid stays high.
        @(negedge clk);
        alu_op = 6'h00; func = 6'h20; input1 = 32'd1; input2 = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        #1 chk("b2b_first", {out_valid, result}, {1'b1, 32'd3});
        func = 6'h22;
        @(posedge clk);
        #1 chk("b2b_second", {out_valid, result}, {1'b1, 32'hFFFFFFFF});
        in_valid = 1'b0;

        // mult -3*7 with an add held during busy.
        @(negedge clk);
        alu_op = 6'h00; func = 6'h18; input1 = 32'hFFFFFFFD; input2 = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 chk("mul_busy", {busy, in_ready}, 2'b10);
        func = 6'h20; input1 = 32'd100; input2 = 32'd99;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("mul_lat", lat, 32);
        chk("mul_hi", hi, 32'hFFFFFFFF); chk("mul_lo", lo, 32'hFFFFFFEB);
        chk("mul_res", result, 32'hFFFFFFEB); chk("mul_zero_wr", {zero, wr_file}, 2'b00);
        chk("mul_idle", {busy, in_ready}, 2'b01);
        @(posedge clk);
        #1 chk("held_add", {out_valid, result, wr_file}, {1'b1, 32'd199, 1'b1});
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("held_add_pulse", out_valid, 0);
        run(6'h00, 6'h12, 32'd0, 32'd0, lat);
        chk("mflo", {lat[7:0], result, wr_file}, {8'd0, 32'hFFFFFFEB, 1'b1});
        run(6'h00, 6'h10, 32'd0, 32'd0, lat);
        chk("mfhi", result, 32'hFFFFFFFF);

        run(6'h00, 6'h1a, 32'hFFFFFFF9, 32'd2, lat);
        chk("div_lat", lat, 32);
        chk("div_lo", lo, 32'hFFFFFFFD); chk("div_hi", hi, 32'hFFFFFFFF); chk("div_dbz", div_by_zero, 0);
        run(6'h00, 6'h1b, 32'd7, 32'd0, lat);
        chk("divz_lat", lat, 32);
        chk("divz_lo", lo, 32'hFFFFFFFF); chk("divz_hi", hi, 32'd7); chk("divz_dbz", div_by_zero, 1);
        chk("divz_res", {result, zero}, {32'hFFFFFFFF, 1'b0});
        run(6'h00, 6'h20, 32'd1, 32'd1, lat);
        chk("dbz_clear", {div_by_zero, result}, {1'b0, 32'd2});

        // multu aborted by reset in mid-iteration.
        @(negedge clk);
        alu_op = 6'h00; func = 6'h19; input1 = 32'hDEADBEEF; input2 = 32'h12345678; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state", {in_ready, busy, out_valid, zero, wr_file, div_by_zero}, 6'b100100);
        chk("abort_data", {result, hi, lo}, 96'd0);
        @(negedge clk) rst_n = 1'b1;
        run(6'h00, 6'h20, 32'd100, 32'd99, lat);
        chk("post_rst_add", {lat[7:0], result}, {8'd0, 32'd199});
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) pulses++;
        end
        chk("abort_no_valid", pulses, 0);

        m_hi = '0; m_lo = '0;
        for (int i = 0; i < 300; i++) begin
            int k;
            logic [5:0] op, fn;
            k = $urandom_range(0, 27);
            op = ops[k];
            fn = (op == 6'h00) ? fns[k] : 6'($urandom);
            ea = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
            eb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            if ($urandom_range(0, 7) == 0) eb = '0;
            model(op, fn, ea, eb, er, ew, multi);
            run(op, fn, ea, eb, lat);
            chk($sformatf("rnd%0d_lat op=%h fn=%h", i, op, fn), lat, multi ? 32 : 0);
            chk($sformatf("rnd%0d_res op=%h fn=%h a=%h b=%h", i, op, fn, ea, eb), result, er);
            chk($sformatf("rnd%0d_zero", i), zero, er == 0);
            chk($sformatf("rnd%0d_wr", i), wr_file, ew);
            chk($sformatf("rnd%0d_hilo", i), {hi, lo}, {m_hi, m_lo});
            chk($sformatf("rnd%0d_dbz", i), div_by_zero, m_dz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Parametrised successor to the single-cycle MIPS ALU. It keeps the single-cycle arithmetic and logic ops and adds an iterative multiply/divide engine with HI/LO registers, a valid/ready input handshake and registered outputs. It sits in the EX stage, between the register-file read and the write-back mux. The `wr_file` output drives the register-file write enable.

## Interface
- `WIDTH`, 32: datapath width; must be a power of two, ≥ 8.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  operands and opcode valid.
- `in_ready`  out  1  unit can accept; high only in IDLE (combinational from state).
- `input1`  in  WIDTH  rs operand / dividend / multiplicand.
- `input2`  in  WIDTH  rt operand or caller-extended immediate / divisor.
- `alu_op`  in  6  instruction opcode.
- `func`  in  6  R-type function field; ignored when `alu_op` ≠ 000000.
- `out_valid`  out  1  one-cycle pulse; result, zero, wr_file, hi, lo and div_by_zero are updated.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  registered, equals (result == 0).
- `wr_file`  out  1  register-file write enable for this result.
- `hi`, `lo`  out  WIDTH  HI/LO architectural registers.
- `busy`  out  1  multi-cycle op in progress.
- `div_by_zero`  out  1  set with out_valid when divisor was 0; cleared on the next out_valid.

## Operation
- Accept when `in_valid` && `in_ready` at a rising edge.
- R-type (`alu_op` 000000), by `func`:
  - 100000/100001 add/addu, wrap, no overflow trap.
  - 100010/100011 sub/subu.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt signed, 101011 sltu.
  - 000100 sllv, 000110 srlv, 000111 srav: shift `input2` by `input1[log2(WIDTH)-1:0]`.
  - 010000 mfhi, 010010 mflo: result = hi / lo.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu: multi-cycle.
- I-type:
  - 001000 addi, 100011 lw, 101011 sw: add.
  - 001100 andi, 001101 ori.
  - 001010 slti (signed).
  - 000100 beq, 000101 bne: sub; branch decision from `zero`.
- `wr_file` = 1 for all R-type single-cycle ops (including mfhi/mflo) and for addi, andi, ori, slti, lw.
- `wr_file` = 0 for sw, beq, bne, mult/div and any unlisted encoding.
- Unlisted encoding: result 0, zero 1, wr_file 0, out_valid still pulses.
- State machine: IDLE, MUL, DIV.
  - IDLE→MUL or IDLE→DIV on accepting a mult/div op.
  - MUL/DIV→IDLE when the iteration counter reaches WIDTH.
- Multiply: radix-2 shift-add, one bit per cycle. Signed mult operates on magnitudes and negates the 2·WIDTH product when operand signs differ.
  - {hi,lo} = full product.
- Divide: restoring, one quotient bit per cycle.
  - lo = quotient, truncated toward zero.
  - hi = remainder, carrying the sign of the dividend.
  - Unsigned for divu.
- Divisor 0:
  - No iteration is skipped; latency is unchanged.
  - lo = all ones, hi = `input1`, `div_by_zero` = 1.
- For mult/div, `result` = new lo and `zero` = (new lo == 0).

## Timing
- Reset values: in_ready 1, out_valid 0, result 0, zero 1, wr_file 0, hi 0, lo 0, busy 0, div_by_zero 0.
- Outputs hold their values between out_valid pulses.
- Single-cycle op accepted at edge N:
  - Outputs update and out_valid is high for the cycle after edge N.
  - in_ready stays 1, so back-to-back accepts are allowed every cycle.
- Multi-cycle op accepted at edge N:
  - busy = 1 and in_ready = 0 from edge N through edge N+WIDTH.
  - hi/lo/result update and out_valid pulses after edge N+WIDTH.
  - A new op can be accepted at edge N+WIDTH+1.
- `in_valid` asserted while in_ready = 0 is ignored; the caller must hold its request.
- mfhi/mflo issued immediately after a mult/div returns the new HI/LO.
- Reset asserted mid-operation: aborts immediately (asynchronous). All outputs go to reset values; no out_valid is produced for the aborted op.
- Operand registers are captured at accept; input changes during busy have no effect.

## Test plan
- add 100+99 at edge N → result 199, zero 0, wr_file 1, out_valid for exactly one cycle after edge N. Repeat with addu, lw, sw; sw gives wr_file 0.
- sub 99−99 → result 0, zero 1, wr_file 1. beq 5,5 → zero 1, wr_file 0. bne 5,4 → zero 0.
- slt −1,1 → 1. sltu 0xFFFFFFFF,1 → 0. srav 0x80000000 by 4 → 0xF8000000. nor 0,0 → 0xFFFFFFFF.
- mult −3·7 → hi 0xFFFFFFFF, lo 0xFFFFFFEB, out_valid exactly 32 cycles after accept; an add held on `in_valid` during busy is accepted only after. A following mflo → 0xFFFFFFEB, wr_file 1.
- div −7/2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF. divu 7/0 → lo 0xFFFFFFFF, hi 7, div_by_zero 1. A subsequent add clears div_by_zero.
- multu started, rst_n pulsed low at cycle 10 → all outputs at reset values, no out_valid. An add issued the cycle after release is accepted immediately.
